line_window_gen: RTL and testbench

Streaming sliding-window generator for the CNN front end. Accepts a raster-order multi-channel pixel stream and emits KX×KY×CH windows for the downstream convolution engine. Compared with the single-channel, stride-1 line buffer it replaces, it adds:
- channel packing
- configurable stride
- gap-tolerant input
- window coordinates on the output
- end-of-frame signalling
- back-to-back frame support

---
 rtl/line_window_gen_if.sv | 28 ++
 rtl/line_window_gen.sv | 139 +++++++++++++
 tb/tb_line_window_gen.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_window_gen_if.sv
// Pixel-in / window-out bundle of the sliding-window generator.
// The slave modport is the generator side, the master modport is the pixel source and window sink.
interface line_window_gen_if #(
    parameter int I_F_BW = 8,
    parameter int CH     = 1,
    parameter int KX     = 5,
    parameter int KY     = 5,
    parameter int WX_W   = 5,
    parameter int WY_W   = 5
);
    logic                         i_in_valid;
    logic [CH*I_F_BW-1:0]         i_in_pixel;
    logic                         o_window_valid;
    logic [KX*KY*CH*I_F_BW-1:0]   o_window;
    logic [WX_W-1:0]              o_win_x;
    logic [WY_W-1:0]              o_win_y;
    logic                         o_frame_done;

    modport master (
        output i_in_valid, i_in_pixel,
        input  o_window_valid, o_window, o_win_x, o_win_y, o_frame_done
    );

    modport slave (
        input  i_in_valid, i_in_pixel,
        output o_window_valid, o_window, o_win_x, o_win_y, o_frame_done
    );
endinterface

// File: rtl/line_window_gen.sv
// Streaming KX x KY x CH sliding-window generator with stride, gap-tolerant input,
// window coordinates and end-of-frame pulse; windows appear one cycle after their last pixel.
module line_window_gen #(
    parameter int I_F_BW = 8,
    parameter int CH     = 1,
    parameter int IX     = 28,
    parameter int IY     = 28,
    parameter int KX     = 5,
    parameter int KY     = 5,
    parameter int STRIDE = 1
) (
    input  logic             clk,
    input  logic             reset,
    line_window_gen_if.slave io_win
);
    localparam int PW  = CH * I_F_BW;
    localparam int OX  = (IX - KX) / STRIDE + 1;
    localparam int OY  = (IY - KY) / STRIDE + 1;
    localparam int XW  = (IX > 1) ? $clog2(IX) : 1;
    localparam int YW  = (IY > 1) ? $clog2(IY) : 1;
    localparam int OXW = (OX > 1) ? $clog2(OX) : 1;
    localparam int OYW = (OY > 1) ? $clog2(OY) : 1;
    localparam int PHW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int WW  = KX * KY * PW;

    logic [XW-1:0]  r_x_cnt;
    logic [YW-1:0]  r_y_cnt;
    logic [PHW-1:0] r_x_ph;
    logic [PHW-1:0] r_y_ph;
    logic [OXW-1:0] r_ox;
    logic [OYW-1:0] r_oy;

    logic [PW-1:0]  r_rowmem [KY-1][IX];
    logic [PW-1:0]  r_col    [KY][KX];
    logic [PW-1:0]  w_col_next [KY][KX];
    logic [WW-1:0]  w_win_flat;

    logic           r_win_vld_p1;
    logic [WW-1:0]  r_window_p1;
    logic [OXW-1:0] r_win_x_p1;
    logic [OYW-1:0] r_win_y_p1;
    logic           r_frame_done_p1;

    logic w_accept, w_x_last, w_y_last, w_x_in, w_y_in, w_hit_x, w_hit_y, w_hit;

    assign w_accept = io_win.i_in_valid & ~reset;
    assign w_x_last = (r_x_cnt == XW'(IX - 1));
    assign w_y_last = (r_y_cnt == YW'(IY - 1));
    assign w_x_in   = (r_x_cnt >= XW'(KX - 1));
    assign w_y_in   = (r_y_cnt >= YW'(KY - 1));
    // Phase zero marks positions on the stride grid relative to the first full window.
    assign w_hit_x  = w_x_in & (r_x_ph == '0);
    assign w_hit_y  = w_y_in & (r_y_ph == '0);
    assign w_hit    = w_accept & w_hit_x & w_hit_y;

    // Window as it stands after shifting in the current pixel's column.
    for (genvar gy = 0; gy < KY; gy++) begin : g_row
        for (genvar gx = 0; gx < KX; gx++) begin : g_colsel
            if (gx < KX - 1) begin : g_shift
                assign w_col_next[gy][gx] = r_col[gy][gx+1];
            end else if (gy == KY - 1) begin : g_pix
                assign w_col_next[gy][gx] = io_win.i_in_pixel;
            end else begin : g_mem
                assign w_col_next[gy][gx] = r_rowmem[gy][r_x_cnt];
            end
            assign w_win_flat[(gy*KX+gx)*PW +: PW] = w_col_next[gy][gx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x_cnt <= '0;
            r_y_cnt <= '0;
            r_x_ph  <= '0;
            r_y_ph  <= '0;
            r_ox    <= '0;
            r_oy    <= '0;
        end else if (w_accept) begin
            if (w_x_last) begin
                r_x_cnt <= '0;
                r_x_ph  <= '0;
                r_ox    <= '0;
                if (w_y_last) begin
                    r_y_cnt <= '0;
                    r_y_ph  <= '0;
                    r_oy    <= '0;
                end else begin
                    r_y_cnt <= r_y_cnt + 1'b1;
                    if (w_y_in) begin
                        r_y_ph <= (r_y_ph == PHW'(STRIDE - 1)) ? '0 : r_y_ph + 1'b1;
                        if (w_hit_y) r_oy <= r_oy + 1'b1;
                    end
                end
            end else begin
                r_x_cnt <= r_x_cnt + 1'b1;
                if (w_x_in) begin
                    r_x_ph <= (r_x_ph == PHW'(STRIDE - 1)) ? '0 : r_x_ph + 1'b1;
                    if (w_hit_x) r_ox <= r_ox + 1'b1;
                end
            end
        end
    end

    // Line storage: never cleared, stale rows are excluded by the y gating.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_col <= w_col_next;
            for (int k = 0; k < KY - 2; k++) begin
                r_rowmem[k][r_x_cnt] <= r_rowmem[k+1][r_x_cnt];
            end
            r_rowmem[KY-2][r_x_cnt] <= io_win.i_in_pixel;
        end
    end

    // Output stage (p1): one cycle after the completing pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_win_vld_p1    <= 1'b0;
            r_frame_done_p1 <= 1'b0;
            r_window_p1     <= '0;
            r_win_x_p1      <= '0;
            r_win_y_p1      <= '0;
        end else begin
            r_win_vld_p1    <= w_hit;
            r_frame_done_p1 <= w_accept & w_x_last & w_y_last;
            if (w_hit) begin
                r_window_p1 <= w_win_flat;
                r_win_x_p1  <= r_ox;
                r_win_y_p1  <= r_oy;
            end
        end
    end

    assign io_win.o_window_valid = r_win_vld_p1;
    assign io_win.o_window       = r_window_p1;
    assign io_win.o_win_x        = r_win_x_p1;
    assign io_win.o_win_y        = r_win_y_p1;
    assign io_win.o_frame_done   = r_frame_done_p1;
endmodule

// File: tb/tb_line_window_gen.sv
// Directed bench for line_window_gen: default, stride-2 and 3-channel instances
// driven from one initial block, each scenario checking its own outputs.
module tb_line_window_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    line_window_gen_if #(.I_F_BW(8), .CH(1), .KX(5), .KY(5), .WX_W(5), .WY_W(5)) a_if ();
    line_window_gen_if #(.I_F_BW(8), .CH(1), .KX(5), .KY(5), .WX_W(4), .WY_W(4)) s_if ();
    line_window_gen_if #(.I_F_BW(8), .CH(3), .KX(3), .KY(3), .WX_W(3), .WY_W(2)) c_if ();

    line_window_gen #(.I_F_BW(8), .CH(1), .IX(28), .IY(28), .KX(5), .KY(5), .STRIDE(1))
        dut_a (.clk(clk), .reset(rst), .io_win(a_if));
    line_window_gen #(.I_F_BW(8), .CH(1), .IX(28), .IY(28), .KX(5), .KY(5), .STRIDE(2))
        dut_s (.clk(clk), .reset(rst), .io_win(s_if));
    line_window_gen #(.I_F_BW(8), .CH(3), .IX(8), .IY(6), .KX(3), .KY(3), .STRIDE(1))
        dut_c (.clk(clk), .reset(rst), .io_win(c_if));

    function automatic int pix(input int x, input int y, input int off);
        return (y * 28 + x + off) % 256;
    endfunction

    function automatic int pixc(input int x, input int y, input int c);
        return (y * 8 + x + 64 * c) % 256;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        a_if.i_in_valid = 1'b0; a_if.i_in_pixel = '0;
        s_if.i_in_valid = 1'b0; s_if.i_in_pixel = '0;
        c_if.i_in_valid = 1'b0; c_if.i_in_pixel = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (a_if.o_window_valid !== 1'b0 || a_if.o_frame_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: vld=%b done=%b, required 0 0", a_if.o_window_valid, a_if.o_frame_done);
        end
        n_checks++;
        if (a_if.o_window !== '0) begin
            n_fail++; $display("FAIL reset_window: got %h, required 0", a_if.o_window);
        end
        n_checks++;
        if (a_if.o_win_x !== '0 || a_if.o_win_y !== '0) begin
            n_fail++; $display("FAIL reset_coord: x=%0d y=%0d, required 0 0", a_if.o_win_x, a_if.o_win_y);
        end
        n_checks++;
        if (s_if.o_window_valid !== 1'b0 || c_if.o_window_valid !== 1'b0 || c_if.o_window !== '0) begin
            n_fail++; $display("FAIL reset_other: s_vld=%b c_vld=%b, required 0 0", s_if.o_window_valid, c_if.o_window_valid);
        end
        rst = 1'b0;
    endtask

    // Drives dut_a with raster frames and checks every cycle's outputs one cycle later.
    task automatic run_a(input int nframes, input int gap_pct, input int abort_at,
                         output int nwin, output int ndone, output int done_gap);
        int x, y, f, acc, pacc, last_done_acc, px, py, poff, off;
        bit pv, prst, started, aborted, have_exp, hit;
        logic [199:0] exp_win, last_exp;
        x = 0; y = 0; f = 0; acc = 0; pacc = 0; last_done_acc = 0;
        px = 0; py = 0; poff = 0; off = 0;
        pv = 0; prst = 0; started = 0; aborted = 0; have_exp = 0; hit = 0;
        nwin = 0; ndone = 0; done_gap = 0; exp_win = '0; last_exp = '0;
        forever begin
            @(negedge clk);
            if (started) begin
                if (prst) begin
                    n_checks++;
                    if (a_if.o_window_valid !== 1'b0 || a_if.o_frame_done !== 1'b0 || a_if.o_window !== '0 ||
                        a_if.o_win_x !== '0 || a_if.o_win_y !== '0) begin
                        n_fail++;
                        $display("FAIL reset_mid: vld=%b done=%b x=%0d y=%0d, required all zero",
                                 a_if.o_window_valid, a_if.o_frame_done, a_if.o_win_x, a_if.o_win_y);
                    end
                    have_exp = 1; last_exp = '0;
                end else if (pv) begin
                    hit = (px >= 4) && (py >= 4);
                    n_checks++;
                    if (a_if.o_window_valid !== hit) begin
                        n_fail++; $display("FAIL a_valid at (%0d,%0d): got %b, required %b", px, py, a_if.o_window_valid, hit);
                    end
                    if (hit) begin
                        for (int ky = 0; ky < 5; ky++)
                            for (int kx = 0; kx < 5; kx++)
                                exp_win[(ky*5+kx)*8 +: 8] = 8'(pix(px - 4 + kx, py - 4 + ky, poff));
                        n_checks++;
                        if (a_if.o_window !== exp_win) begin
                            n_fail++; $display("FAIL a_window at (%0d,%0d): got %h, required %h", px, py, a_if.o_window, exp_win);
                        end
                        n_checks++;
                        if (a_if.o_win_x !== 5'(px - 4) || a_if.o_win_y !== 5'(py - 4)) begin
                            n_fail++; $display("FAIL a_coord at (%0d,%0d): got (%0d,%0d), required (%0d,%0d)",
                                               px, py, a_if.o_win_x, a_if.o_win_y, px - 4, py - 4);
                        end
                        if (aborted || abort_at < 0) nwin++;
                        last_exp = exp_win; have_exp = 1;
                    end
                    n_checks++;
                    if (a_if.o_frame_done !== (px == 27 && py == 27)) begin
                        n_fail++; $display("FAIL a_frame_done at (%0d,%0d): got %b, required %b", px, py, a_if.o_frame_done, (px == 27 && py == 27));
                    end
                    if (a_if.o_frame_done === 1'b1) begin
                        ndone++;
                        if (ndone > 1) done_gap = pacc - last_done_acc;
                        last_done_acc = pacc;
                    end
                end else begin
                    n_checks++;
                    if (a_if.o_window_valid !== 1'b0 || a_if.o_frame_done !== 1'b0) begin
                        n_fail++; $display("FAIL a_gap_quiet: vld=%b done=%b, required 0 0", a_if.o_window_valid, a_if.o_frame_done);
                    end
                    if (have_exp) begin
                        n_checks++;
                        if (a_if.o_window !== last_exp) begin
                            n_fail++; $display("FAIL a_gap_hold: got %h, required %h", a_if.o_window, last_exp);
                        end
                    end
                end
            end
            if (f >= nframes) break;
            started = 1;
            if (abort_at >= 0 && !aborted && acc == abort_at) begin
                rst = 1'b1;
                a_if.i_in_valid = 1'b1;
                a_if.i_in_pixel = 8'(pix(x, y, 50));
                prst = 1; pv = 0; aborted = 1; x = 0; y = 0;
            end else begin
                rst = 1'b0; prst = 0;
                if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                    a_if.i_in_valid = 1'b0;
                    a_if.i_in_pixel = 8'($urandom);
                    pv = 0;
                end else begin
                    off = (abort_at >= 0 && !aborted) ? 50 : f * 100;
                    a_if.i_in_valid = 1'b1;
                    a_if.i_in_pixel = 8'(pix(x, y, off));
                    pv = 1; px = x; py = y; poff = off;
                    acc++; pacc = acc;
                    if (x == 27) begin
                        x = 0;
                        if (y == 27) begin y = 0; f++; end
                        else y++;
                    end else x++;
                end
            end
        end
        a_if.i_in_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int nwin, ndone, gap;
        run_a(1, 0, -1, nwin, ndone, gap);
        n_checks++;
        if (nwin !== 576) begin n_fail++; $display("FAIL basic_count: got %0d windows, required 576", nwin); end
        n_checks++;
        if (ndone !== 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses, required 1", ndone); end
    endtask

    task automatic test_gaps();
        int nwin, ndone, gap;
        run_a(1, 40, -1, nwin, ndone, gap);
        n_checks++;
        if (nwin !== 576) begin n_fail++; $display("FAIL gaps_count: got %0d windows, required 576", nwin); end
        n_checks++;
        if (ndone !== 1) begin n_fail++; $display("FAIL gaps_done: got %0d pulses, required 1", ndone); end
    endtask

    task automatic test_back_to_back();
        int nwin, ndone, gap;
        run_a(2, 0, -1, nwin, ndone, gap);
        n_checks++;
        if (nwin !== 1152) begin n_fail++; $display("FAIL b2b_count: got %0d windows, required 1152", nwin); end
        n_checks++;
        if (ndone !== 2 || gap !== 784) begin
            n_fail++; $display("FAIL b2b_done: got %0d pulses %0d apart, required 2 pulses 784 apart", ndone, gap);
        end
    endtask

    task automatic test_reset_mid();
        int nwin, ndone, gap;
        run_a(1, 0, 12 * 28 + 10, nwin, ndone, gap);
        n_checks++;
        if (nwin !== 576) begin n_fail++; $display("FAIL rstmid_count: got %0d windows, required 576", nwin); end
        n_checks++;
        if (ndone !== 1) begin n_fail++; $display("FAIL rstmid_done: got %0d pulses, required 1", ndone); end
    endtask

    task automatic test_stride();
        int px, py, nwin, ndone;
        bit hit;
        logic [199:0] exp_win;
        nwin = 0; ndone = 0; px = 0; py = 0; hit = 0; exp_win = '0;
        for (int i = 0; i <= 784; i++) begin
            @(negedge clk);
            if (i > 0) begin
                px = (i - 1) % 28; py = (i - 1) / 28;
                hit = (px >= 4) && (py >= 4) && ((px - 4) % 2 == 0) && ((py - 4) % 2 == 0);
                n_checks++;
                if (s_if.o_window_valid !== hit) begin
                    n_fail++; $display("FAIL s_valid at (%0d,%0d): got %b, required %b", px, py, s_if.o_window_valid, hit);
                end
                if (hit) begin
                    nwin++;
                    for (int ky = 0; ky < 5; ky++)
                        for (int kx = 0; kx < 5; kx++)
                            exp_win[(ky*5+kx)*8 +: 8] = 8'(pix(px - 4 + kx, py - 4 + ky, 0));
                    n_checks++;
                    if (s_if.o_window !== exp_win || s_if.o_win_x !== 4'((px - 4) / 2) || s_if.o_win_y !== 4'((py - 4) / 2)) begin
                        n_fail++; $display("FAIL s_window at (%0d,%0d): got (%0d,%0d) %h, required (%0d,%0d) %h",
                                           px, py, s_if.o_win_x, s_if.o_win_y, s_if.o_window, (px - 4) / 2, (py - 4) / 2, exp_win);
                    end
                    if (px == 6 && py == 4) begin
                        n_checks++;
                        if (s_if.o_window[7:0] !== 8'd2) begin
                            n_fail++; $display("FAIL s_win10_e00: got %0d, required 2", s_if.o_window[7:0]);
                        end
                    end
                end
                n_checks++;
                if (s_if.o_frame_done !== (i == 784)) begin
                    n_fail++; $display("FAIL s_frame_done at (%0d,%0d): got %b", px, py, s_if.o_frame_done);
                end
                if (s_if.o_frame_done === 1'b1) ndone++;
            end
            if (i < 784) begin
                s_if.i_in_valid = 1'b1;
                s_if.i_in_pixel = 8'(pix(i % 28, i / 28, 0));
            end else s_if.i_in_valid = 1'b0;
        end
        n_checks++;
        if (nwin !== 144 || ndone !== 1) begin
            n_fail++; $display("FAIL s_count: got %0d windows %0d done, required 144 and 1", nwin, ndone);
        end
    endtask

    task automatic test_channels();
        int px, py, nwin;
        bit hit;
        logic [215:0] exp_win;
        nwin = 0; px = 0; py = 0; hit = 0; exp_win = '0;
        for (int i = 0; i <= 48; i++) begin
            @(negedge clk);
            if (i > 0) begin
                px = (i - 1) % 8; py = (i - 1) / 8;
                hit = (px >= 2) && (py >= 2);
                n_checks++;
                if (c_if.o_window_valid !== hit || c_if.o_frame_done !== (i == 48)) begin
                    n_fail++; $display("FAIL c_ctrl at (%0d,%0d): vld=%b done=%b, required %b %b",
                                       px, py, c_if.o_window_valid, c_if.o_frame_done, hit, (i == 48));
                end
                if (hit) begin
                    nwin++;
                    for (int ky = 0; ky < 3; ky++)
                        for (int kx = 0; kx < 3; kx++)
                            for (int c = 0; c < 3; c++)
                                exp_win[((ky*3+kx)*3+c)*8 +: 8] = 8'(pixc(px - 2 + kx, py - 2 + ky, c));
                    n_checks++;
                    if (c_if.o_window !== exp_win || c_if.o_win_x !== 3'(px - 2) || c_if.o_win_y !== 2'(py - 2)) begin
                        n_fail++; $display("FAIL c_window at (%0d,%0d): got (%0d,%0d) %h, required (%0d,%0d) %h",
                                           px, py, c_if.o_win_x, c_if.o_win_y, c_if.o_window, px - 2, py - 2, exp_win);
                    end
                    if (px == 2 && py == 2) begin
                        n_checks++;
                        if (c_if.o_window[215:208] !== 8'd146) begin
                            n_fail++; $display("FAIL c_e22c2: got %0d, required 146", c_if.o_window[215:208]);
                        end
                    end
                end
            end
            if (i < 48) begin
                c_if.i_in_valid = 1'b1;
                c_if.i_in_pixel = {8'(pixc(i % 8, i / 8, 2)), 8'(pixc(i % 8, i / 8, 1)), 8'(pixc(i % 8, i / 8, 0))};
            end else c_if.i_in_valid = 1'b0;
        end
        n_checks++;
        if (nwin !== 24) begin n_fail++; $display("FAIL c_count: got %0d windows, required 24", nwin); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stride();
        test_channels();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
